// File: rtl/imm_encoder.sv
// Streaming immediate encoder: the inverse of ID-stage immediate decode.
// It takes a signed 32-bit immediate, an immediate format and a template
// instruction. It returns the template with its immediate fields overwritten.
// Two-stage valid/ready pipeline:
//   S1 registers the request and the representability check.
//   S2 registers the packed {instr, err} result.
// A saturating counter tracks errored results.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake
//   in_sel              immediate format (immgen_t)
//   in_imm              two's complement immediate
//   in_instr            template instruction
//   out_valid/out_ready result handshake
//   out_instr           encoded instruction
//   out_err             immediate not representable, or illegal format
//   err_count           saturating count of delivered results with out_err=1

package imm_encoder_pkg;

    typedef enum logic [2:0] {
        IMMGEN_I  = 3'd0,
        IMMGEN_S  = 3'd1,
        IMMGEN_SB = 3'd2,
        IMMGEN_UJ = 3'd3,
        IMMGEN_U  = 3'd4
    } immgen_t;

    // S2 payload
    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } enc_result_t;

endpackage

module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  immgen_t              in_sel,
    input  logic [31:0]          in_imm,
    input  logic [31:0]          in_instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned XLEN = 32;

    // Stage 1 state
    logic              r_s1_valid;
    immgen_t           r_s1_sel;
    logic [XLEN-1:0]   r_s1_imm;
    logic [XLEN-1:0]   r_s1_instr;
    logic              r_s1_err;

    // Stage 2 state
    logic              r_s2_valid;
    enc_result_t       r_s2;

    logic [ERR_CNT_W-1:0] r_err_count;

    logic              w_s1_ready;
    logic              w_s2_ready;
    logic              w_in_err;
    logic [XLEN-1:0]   w_pack;

    // Each stage accepts when it is empty or its contents move on this cycle.
    assign w_s2_ready = !r_s2_valid || out_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign in_ready   = w_s1_ready;

    // Representability check.
    // An immediate fits when all bits above its top field bit are sign copies.
    always_comb begin
        w_in_err = 1'b1;
        case (in_sel)
            IMMGEN_I, IMMGEN_S:
                w_in_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            IMMGEN_SB:
                w_in_err = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
            IMMGEN_UJ:
                w_in_err = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
            IMMGEN_U:
                w_in_err = |in_imm[11:0];
            default:
                w_in_err = 1'b1;
        endcase
    end

    // S1 register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sel   <= IMMGEN_I;
            r_s1_imm   <= '0;
            r_s1_instr <= '0;
            r_s1_err   <= 1'b0;
        end else if (w_s1_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sel   <= in_sel;
                r_s1_imm   <= in_imm;
                r_s1_instr <= in_instr;
                r_s1_err   <= w_in_err;
            end
        end
    end

    // Field packing.
    // Errored requests pass the template through untouched.
    always_comb begin
        w_pack = r_s1_instr;
        if (!r_s1_err) begin
            case (r_s1_sel)
                IMMGEN_I: begin
                    w_pack[31:20] = r_s1_imm[11:0];
                end
                IMMGEN_S: begin
                    w_pack[31:25] = r_s1_imm[11:5];
                    w_pack[11:7]  = r_s1_imm[4:0];
                end
                IMMGEN_SB: begin
                    w_pack[31]    = r_s1_imm[12];
                    w_pack[30:25] = r_s1_imm[10:5];
                    w_pack[11:8]  = r_s1_imm[4:1];
                    w_pack[7]     = r_s1_imm[11];
                end
                IMMGEN_UJ: begin
                    w_pack[31]    = r_s1_imm[20];
                    w_pack[30:21] = r_s1_imm[10:1];
                    w_pack[20]    = r_s1_imm[11];
                    w_pack[19:12] = r_s1_imm[19:12];
                end
                IMMGEN_U: begin
                    w_pack[31:12] = r_s1_imm[31:12];
                end
                default: begin
                    w_pack = r_s1_instr;
                end
            endcase
        end
    end

    // S2 register.
    // The payload is only loaded on a move, so it holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2.instr <= w_pack;
                r_s2.err   <= r_s1_err;
            end
        end
    end

    // Saturating count of errored results that were actually consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (r_s2_valid && out_ready && r_s2.err
                     && (r_err_count != {ERR_CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
        end
    end

    assign out_valid = r_s2_valid;
    assign out_instr = r_s2.instr;
    assign out_err   = r_s2.err;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_imm_encoder.sv
// Testbench for imm_encoder.
// Vectors are applied through a valid/ready driver.
// A scoreboard queue holds expected results, which are checked by a negedge monitor.
// The monitor also checks err_count and output stability under stall.
// Hand-written sequences cover:
//   - latency
//   - backpressure
//   - reset flush
//   - counter saturation

module tb_imm_encoder;
    import imm_encoder_pkg::*;

    localparam int unsigned CW   = 4;
    localparam int unsigned NVEC = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    immgen_t       in_sel;
    logic [31:0]   in_imm;
    logic [31:0]   in_instr;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic          out_err;
    logic [CW-1:0] err_count;

    always #5 clk = ~clk;

    imm_encoder #(.ERR_CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_imm    (in_imm),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    typedef struct {
        immgen_t     sel;
        logic [31:0] imm;
        logic [31:0] tmpl;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    vec_t          vecs [NVEC];
    exp_t          sb_q [$];
    exp_t          mon_e;
    int            errors   = 0;
    int            checks   = 0;
    int            hs_count = 0;
    logic [CW-1:0] exp_cnt  = '0;
    bit            bp_rand  = 1'b0;
    logic          stall_prev = 1'b0;
    logic [31:0]   stall_instr;
    logic          stall_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
        end
    endtask

    // Drive one request; push its expectation when the handshake happens.
    // Called and returns at posedge+1.
    task automatic send(input immgen_t sel, input logic [31:0] imm, input logic [31:0] tmpl,
                        input logic [31:0] exp_i, input logic exp_e);
        exp_t e;
        bit   ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_imm   = imm;
        in_instr = tmpl;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            if (ok) begin
                e.instr = exp_i;
                e.err   = exp_e;
                sb_q.push_back(e);
            end
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: actual=in_ready stuck low required=accept imm=0x%08h", imm);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && sb_q.size() != 0; n++) @(posedge clk);
        #1;
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_instr", out_instr, stall_instr);
                check("hold_err", 32'(out_err), 32'(stall_err));
            end
            if (out_valid && out_ready) begin
                hs_count++;
                check("err_count", 32'(err_count), 32'(exp_cnt));
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: actual=0x%08h required=no output", out_instr);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("out_instr", out_instr, mon_e.instr);
                    check("out_err", 32'(out_err), 32'(mon_e.err));
                    if (mon_e.err && exp_cnt != '1) exp_cnt = exp_cnt + CW'(1);
                end
            end
            stall_prev  = out_valid && !out_ready;
            stall_instr = out_instr;
            stall_err   = out_err;
        end
    end

    // Random output backpressure, enabled only during one table pass
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_rand) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h0;
        vecs[0]  = '{IMMGEN_I,  32'hFFFFF800, 32'h00000013, 32'h80000013, 1'b0};
        vecs[1]  = '{IMMGEN_I,  32'h00000800, 32'h00000013, 32'h00000013, 1'b1};
        vecs[2]  = '{IMMGEN_I,  32'h000007FF, 32'h00A00093, 32'h7FF00093, 1'b0};
        vecs[3]  = '{IMMGEN_I,  32'h00000001, 32'hFFF00093, 32'h00100093, 1'b0};
        vecs[4]  = '{IMMGEN_S,  32'hFFFFF800, 32'h00112023, 32'h80112023, 1'b0};
        vecs[5]  = '{IMMGEN_S,  32'h00000025, 32'h00112023, 32'h021122A3, 1'b0};
        vecs[6]  = '{IMMGEN_S,  32'hFFFFF7FF, 32'h00112023, 32'h00112023, 1'b1};
        vecs[7]  = '{IMMGEN_SB, 32'hFFFFFFFC, 32'h00000063, 32'hFE000EE3, 1'b0};
        vecs[8]  = '{IMMGEN_SB, 32'h00000002, 32'h00000063, 32'h00000163, 1'b0};
        vecs[9]  = '{IMMGEN_SB, 32'h00000003, 32'h00000063, 32'h00000063, 1'b1};
        vecs[10] = '{IMMGEN_SB, 32'h00001000, 32'h00000063, 32'h00000063, 1'b1};
        vecs[11] = '{IMMGEN_SB, 32'hFFFFF000, 32'h00000063, 32'h80000063, 1'b0};
        vecs[12] = '{IMMGEN_UJ, 32'h00000800, 32'h0000006F, 32'h0010006F, 1'b0};
        vecs[13] = '{IMMGEN_UJ, 32'h000FFFFE, 32'h0000006F, 32'h7FFFF06F, 1'b0};
        vecs[14] = '{IMMGEN_UJ, 32'h00100000, 32'h0000006F, 32'h0000006F, 1'b1};
        vecs[15] = '{IMMGEN_U,  32'h12345000, 32'h00000037, 32'h12345037, 1'b0};
        vecs[16] = '{IMMGEN_U,  32'h12345001, 32'h00000037, 32'h00000037, 1'b1};
        vecs[17] = '{immgen_t'(3'd7), 32'h00000000, 32'h00000013, 32'h00000013, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = IMMGEN_I;
        in_imm    = '0;
        in_instr  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Two-cycle latency
        send(IMMGEN_I, 32'hFFFFF800, 32'h00000013, 32'h80000013, 1'b0);
        @(negedge clk);
        check("lat_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_cycle2_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        drain();

        // Table pass, back-to-back
        for (int i = 0; i < NVEC; i++)
            send(vecs[i].sel, vecs[i].imm, vecs[i].tmpl, vecs[i].exp_instr, vecs[i].exp_err);
        drain();
        @(posedge clk);
        #1;
        check("err_count_pass1", 32'(err_count), 32'd7);

        // Table pass under random backpressure
        bp_rand = 1'b1;
        for (int i = 0; i < NVEC; i++)
            send(vecs[i].sel, vecs[i].imm, vecs[i].tmpl, vecs[i].exp_instr, vecs[i].exp_err);
        bp_rand = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();
        @(posedge clk);
        #1;
        check("err_count_pass2", 32'(err_count), 32'd14);

        // Backpressure: only two beats fit, third waits
        out_ready = 1'b0;
        send(IMMGEN_S,  32'h00000025, 32'h00112023, 32'h021122A3, 1'b0);
        send(IMMGEN_SB, 32'h00000002, 32'h00000063, 32'h00000163, 1'b0);
        in_valid = 1'b1;
        in_sel   = IMMGEN_UJ;
        in_imm   = 32'h00000800;
        in_instr = 32'h0000006F;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_out_hold", out_instr, 32'h021122A3);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        h0 = hs_count;
        @(negedge clk);
        check("bp_in_ready_high", 32'(in_ready), 32'd1);
        @(posedge clk);
        mon_e.instr = 32'h0010006F;
        mon_e.err   = 1'b0;
        sb_q.push_back(mon_e);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        check("bp_drain_rate", 32'(hs_count - h0), 32'd3);
        drain();

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(IMMGEN_I, 32'h00000005, 32'h00000013, 32'h00500013, 1'b0);
        send(IMMGEN_U, 32'h00000001, 32'h00000037, 32'h00000037, 1'b1);
        rst = 1'b1;
        sb_q.delete();
        exp_cnt = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_err_count", 32'(err_count), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        send(IMMGEN_U, 32'hABCDE000, 32'h00000137, 32'hABCDE137, 1'b0);
        @(negedge clk);
        check("post_rst_lat1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("post_rst_lat2", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        drain();

        // err_count saturation
        for (int i = 0; i < 20; i++)
            send(IMMGEN_U, 32'h00000001, 32'h00000037, 32'h00000037, 1'b1);
        drain();
        @(posedge clk);
        #1;
        check("err_count_sat", 32'(err_count), 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
